game_sequencer: RTL and testbench
=================================

# game_sequencer

Game-flow controller for the brick-breaker top level. It sits between the board buttons and the ball/brick/VGA/7-segment datapath. It debounces `leftButton`/`rightButton`, moves the paddle once per video frame, and sequences the ATTRACT→SERVE→PLAY→OVER/WIN flow. It also keeps lives and a BCD score for the 7-segment driver.

## Interface
- `SCREEN_W`, 640: visible width in pixels.
- `PADDLE_W`, 64: paddle width in pixels.
- `PADDLE_STEP`, 4: pixels moved per frameTick.
- `LIVES`, 3: lives per game, range 1..3.
- `SERVE_FRAMES`, 60: frames the ball is held on the paddle before launch.
- `DEBOUNCE`, 16: cycles a synchronized button must be stable before its level is accepted.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `leftButton`, `rightButton` in 1: raw asynchronous buttons.
- `frameTick` in 1: one-cycle pulse per frame, from the VGA timing block.
- `ballLost` in 1: one-cycle pulse when the ball passes the paddle line.
- `brickHit` in 1: one-cycle pulse per destroyed brick.
- `bricksCleared` in 1: level, high when no bricks remain.
- `paddleX` out 10: left edge of the paddle.
- `ballEnable` out 1: ball physics runs.
- `ballReset` out 1: one-cycle pulse; ball is re-placed on the paddle.
- `brickReset` out 1: one-cycle pulse; brick map is reloaded.
- `lives` out 2: remaining lives.
- `score` out 16: four BCD digits, [15:12] most significant.
- `gameState` out 3: current state encoding, used by the renderer.

## Operation
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a debouncer (counter resets on any change).
  - The debounced level toggles after `DEBOUNCE` consecutive differing samples.
  - A `press` is the one-cycle rising edge of the debounced level.
- States: ATTRACT=0, SERVE=1, PLAY=2, OVER=3, WIN=4.
- ATTRACT:
  - `ballEnable`=0; paddle frozen at centre.
  - Any press starts a new game and goes to SERVE. Starting a new game means: lives←`LIVES`, score←0, paddle←centre, pulse `brickReset` and `ballReset`.
- SERVE:
  - `ballEnable`=0; the paddle moves.
  - Frame counter clears on entry and increments per frameTick.
  - Reaching `SERVE_FRAMES` goes to PLAY.
- PLAY:
  - `ballEnable`=1; the paddle moves.
  - `brickHit` adds 1 to the BCD score with decimal carry, saturating at 9999.
  - `bricksCleared`=1 goes to WIN.
  - `ballLost` decrements lives:
    - if lives was 1: lives←0, go to OVER;
    - else go to SERVE and pulse `ballReset`.
- OVER / WIN:
  - `ballEnable`=0; paddle frozen.
  - Any press starts a new game (as in ATTRACT) and goes to SERVE.
- Paddle update, once per frameTick in SERVE/PLAY, using debounced levels:
  - left only: `paddleX`←max(0, `paddleX`−`PADDLE_STEP`);
  - right only: `paddleX`←min(`SCREEN_W`−`PADDLE_W`, `paddleX`+`PADDLE_STEP`);
  - both or neither: hold.
  - Arithmetic is 11-bit to avoid wrap-around.
- Simultaneous events in PLAY:
  - `bricksCleared` beats `ballLost`: go to WIN, lives unchanged.
  - `brickHit` is always scored in the same cycle, including with `ballLost`.
  - `ballLost`/`brickHit` are ignored outside PLAY.

## Timing
- Reset values:
  - state ATTRACT;
  - `paddleX`=(`SCREEN_W`−`PADDLE_W`)/2=288;
  - `ballEnable`=0, `ballReset`=0, `brickReset`=0;
  - `lives`=`LIVES`, `score`=0, `gameState`=0;
  - debouncers and counters cleared, debounced levels 0.
- All outputs are registered; state changes appear one cycle after the triggering input cycle.
- Button latency: raw edge → `press` in 2+`DEBOUNCE`+1 cycles. Glitches shorter than `DEBOUNCE` cycles are never seen.
- `ballReset`/`brickReset` are high for exactly the first cycle of the new state.
- `paddleX` changes in the cycle after frameTick.
- A new `score`/`lives` value is visible in the cycle after its event.
- `reset` asserted mid-game returns every output to its reset value on the next edge.

## Structure
- Package `game_pkg` holds:
  - the state enum and its 3-bit encoding;
  - `PADDLE_X_W`=10;
  - the BCD digit type.
- One sub-module, `button_debouncer`, instantiated twice: synchronizer + counter + edge detect; outputs `level`, `press`.

## Test plan
- **Debounce:** `DEBOUNCE`=16, pulse `leftButton` for 10 cycles → no `press`, state stays ATTRACT. Hold it for 25 cycles → exactly one `press`, state SERVE, `brickReset` and `ballReset` each high for one cycle.
- **Paddle limits:** in SERVE, hold right for 100 frameTicks → `paddleX` climbs 288→576 in steps of 4, then stays at 576. Hold left → reaches 0 and stays. Both held → no change.
- **Serve timing:** `SERVE_FRAMES`=60 → `ballEnable` rises in the cycle after the 60th frameTick.
- **Scoring:** in PLAY, 1005 `brickHit` pulses → `score`=16'h1005. Forcing the score to 9999 and pulsing `brickHit` → stays 9999.
- **Lives:** three `ballLost` pulses, each after re-serving → `lives` 3→2→1→0, final state OVER. A subsequent press → SERVE, `lives`=3, `score`=0.
- **Priority and reset:** `ballLost` and `bricksCleared` in the same cycle → WIN, lives unchanged. `reset` during PLAY → all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, paddle width and BCD helpers for the game sequencer.
package game_pkg;
    typedef enum logic [2:0] {
        ATTRACT = 3'd0,
        SERVE   = 3'd1,
        PLAY    = 3'd2,
        OVER    = 3'd3,
        WIN     = 3'd4
    } state_t;

    localparam int PADDLE_X_W = 10;

    typedef logic [3:0] bcd_t;

    // Four-digit BCD increment that sticks at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic c;
        bcd_t d;
        r = s;
        c = 1'b1;
        if (s == 16'h9999) return s;
        for (int i = 0; i < 4; i++) begin
            d = s[4*i +: 4];
            r[4*i +: 4] = c ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
            c = c && (d == 4'd9);
        end
        return r;
    endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchronizer, stability counter and rising-edge press pulse.
module button_debouncer #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            level_q <= level;
            press   <= level & ~level_q;
            if (sync[1] == level) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: brick-breaker game flow, paddle motion, lives and BCD score.
module game_sequencer
    import game_pkg::*;
#(
    parameter int SCREEN_W     = 640,
    parameter int PADDLE_W     = 64,
    parameter int PADDLE_STEP  = 4,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int DEBOUNCE     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  leftButton,
    input  logic                  rightButton,
    input  logic                  frameTick,
    input  logic                  ballLost,
    input  logic                  brickHit,
    input  logic                  bricksCleared,
    output logic [PADDLE_X_W-1:0] paddleX,
    output logic                  ballEnable,
    output logic                  ballReset,
    output logic                  brickReset,
    output logic [1:0]            lives,
    output logic [15:0]           score,
    output logic [2:0]            gameState
);
    localparam int                    FW     = $clog2(SERVE_FRAMES + 1);
    localparam logic [10:0]           X_MAX  = 11'(SCREEN_W - PADDLE_W);
    localparam logic [10:0]           STEP   = 11'(PADDLE_STEP);
    localparam logic [PADDLE_X_W-1:0] CENTRE = PADDLE_X_W'((SCREEN_W - PADDLE_W) / 2);

    state_t                  state, state_n;
    logic [FW-1:0]           frames, frames_n;
    logic [PADDLE_X_W-1:0]   paddle_n, px_move;
    logic [10:0]             px;
    logic [1:0]              lives_n;
    logic [15:0]             score_n;
    logic                    ball_reset_n, brick_reset_n;
    logic                    left_level, left_press, right_level, right_press;

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_left (
        .clk(clk), .reset(reset), .raw(leftButton), .level(left_level), .press(left_press)
    );
    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_right (
        .clk(clk), .reset(reset), .raw(rightButton), .level(right_level), .press(right_press)
    );

    assign gameState = state;

    always_comb begin
        px            = {1'b0, paddleX};
        // 11-bit math so the clamps see underflow/overflow before truncation
        px_move       = (left_level & ~right_level) ? PADDLE_X_W'((px < STEP) ? 11'd0 : px - STEP) :
                        (right_level & ~left_level) ? PADDLE_X_W'((px + STEP > X_MAX) ? X_MAX : px + STEP) :
                        paddleX;
        state_n       = state;
        frames_n      = frames;
        paddle_n      = paddleX;
        lives_n       = lives;
        score_n       = score;
        ball_reset_n  = 1'b0;
        brick_reset_n = 1'b0;
        case (state)
            ATTRACT, OVER, WIN: begin
                if (left_press | right_press) begin
                    state_n       = SERVE;
                    frames_n      = '0;
                    paddle_n      = CENTRE;
                    lives_n       = 2'(LIVES);
                    score_n       = '0;
                    ball_reset_n  = 1'b1;
                    brick_reset_n = 1'b1;
                end
            end
            SERVE: begin
                if (frameTick) begin
                    paddle_n = px_move;
                    frames_n = frames + 1'b1;
                    if (frames_n == FW'(SERVE_FRAMES)) state_n = PLAY;
                end
            end
            PLAY: begin
                if (frameTick) paddle_n = px_move;
                if (brickHit) score_n = bcd_inc(score);
                if (bricksCleared) state_n = WIN;
                else if (ballLost) begin
                    lives_n      = lives - 2'd1;
                    state_n      = (lives == 2'd1) ? OVER : SERVE;
                    ball_reset_n = (lives != 2'd1);
                    frames_n     = '0;
                end
            end
            default: state_n = ATTRACT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ATTRACT;
            frames     <= '0;
            paddleX    <= CENTRE;
            lives      <= 2'(LIVES);
            score      <= '0;
            ballEnable <= 1'b0;
            ballReset  <= 1'b0;
            brickReset <= 1'b0;
        end else begin
            state      <= state_n;
            frames     <= frames_n;
            paddleX    <= paddle_n;
            lives      <= lives_n;
            score      <= score_n;
            ballEnable <= (state_n == PLAY);
            ballReset  <= ball_reset_n;
            brickReset <= brick_reset_n;
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scoreboard bench for game_sequencer.
module tb_game_sequencer;
    logic        clk = 1'b0, reset = 1'b1;
    logic        leftButton = 1'b0, rightButton = 1'b0, frameTick = 1'b0;
    logic        ballLost = 1'b0, brickHit = 1'b0, bricksCleared = 1'b0;
    logic [9:0]  paddleX;
    logic        ballEnable, ballReset, brickReset;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [2:0]  gameState;

    game_sequencer dut (
        .clk(clk), .reset(reset), .leftButton(leftButton), .rightButton(rightButton),
        .frameTick(frameTick), .ballLost(ballLost), .brickHit(brickHit),
        .bricksCleared(bricksCleared), .paddleX(paddleX), .ballEnable(ballEnable),
        .ballReset(ballReset), .brickReset(brickReset), .lives(lives), .score(score),
        .gameState(gameState)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors = 0;
    int   mpx = 288;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [15:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (obs === e.val)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic check_reset();
        expect_val("rst_paddleX", 16'd288);
        expect_val("rst_ballEnable", 16'd0);
        expect_val("rst_ballReset", 16'd0);
        expect_val("rst_brickReset", 16'd0);
        expect_val("rst_lives", 16'd3);
        expect_val("rst_score", 16'd0);
        expect_val("rst_gameState", 16'd0);
        compare(16'(paddleX));
        compare(16'(ballEnable));
        compare(16'(ballReset));
        compare(16'(brickReset));
        compare(16'(lives));
        compare(score);
        compare(16'(gameState));
    endtask

    // dir: -1 left, +1 right, 0 hold; en is the expected ballEnable after the tick
    task automatic step_frame(input int dir, input logic en);
        mpx = (dir < 0) ? ((mpx < 4) ? 0 : mpx - 4) : (dir > 0) ? ((mpx + 4 > 576) ? 576 : mpx + 4) : mpx;
        expect_val("paddleX", 16'(mpx));
        expect_val("ballEnable", {15'd0, en});
        frameTick = 1'b1;
        tick();
        frameTick = 1'b0;
        compare(16'(paddleX));
        compare(16'(ballEnable));
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (gameState !== s && n < 60) begin
            tick();
            n++;
        end
        expect_val(tag, 16'(s));
        compare(16'(gameState));
    endtask

    task automatic serve();
        for (int i = 1; i <= 60; i++) step_frame(0, i == 60);
        expect_val("serve_to_play", 16'd2);
        compare(16'(gameState));
    endtask

    task automatic hold(input logic l, input logic r);
        leftButton  = l;
        rightButton = r;
        repeat (25) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, nbr, nbl;
        reset = 1'b1;
        repeat (2) tick();
        check_reset();
        reset = 1'b0;
        tick();

        leftButton = 1'b1;
        repeat (10) tick();
        leftButton = 1'b0;
        repeat (30) tick();
        expect_val("glitch_ignored", 16'd0);
        compare(16'(gameState));

        first = -1;
        nbr = 0;
        nbl = 0;
        leftButton = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (gameState == 3'd1 && first < 0) first = i;
            nbr += int'(brickReset);
            nbl += int'(ballReset);
        end
        expect_val("press_latency", 16'd20);
        expect_val("brickReset_pulses", 16'd1);
        expect_val("ballReset_pulses", 16'd1);
        expect_val("state_serve", 16'd1);
        compare(16'(first));
        compare(16'(nbr));
        compare(16'(nbl));
        compare(16'(gameState));
        hold(1'b0, 1'b0);

        mpx = 288;
        hold(1'b0, 1'b1);
        for (int i = 1; i <= 100; i++) step_frame(1, i >= 60);
        expect_val("state_play", 16'd2);
        compare(16'(gameState));
        hold(1'b1, 1'b0);
        for (int i = 1; i <= 150; i++) step_frame(-1, 1'b1);
        hold(1'b1, 1'b1);
        repeat (5) step_frame(0, 1'b1);
        hold(1'b0, 1'b0);

        for (int n = 1; n <= 10002; n++) begin
            expect_val("score", to_bcd((n > 9999) ? 9999 : n));
            if (n == 1005) expect_val("score_1005", 16'h1005);
            brickHit = 1'b1;
            tick();
            brickHit = 1'b0;
            compare(score);
            if (n == 1005) compare(score);
            tick();
        end

        for (int k = 1; k <= 3; k++) begin
            expect_val("lives", 16'(3 - k));
            expect_val("state_after_loss", (k == 3) ? 16'd3 : 16'd1);
            expect_val("ballReset_on_loss", (k < 3) ? 16'd1 : 16'd0);
            ballLost = 1'b1;
            tick();
            ballLost = 1'b0;
            compare(16'(lives));
            compare(16'(gameState));
            compare(16'(ballReset));
            if (k < 3) serve();
        end

        ballLost = 1'b1;
        brickHit = 1'b1;
        tick();
        ballLost = 1'b0;
        brickHit = 1'b0;
        tick();
        expect_val("over_ignores_lost", 16'd0);
        expect_val("over_ignores_hit", 16'h9999);
        compare(16'(lives));
        compare(score);

        rightButton = 1'b1;
        wait_state(3'd1, "restart_serve");
        mpx = 288;
        expect_val("restart_lives", 16'd3);
        expect_val("restart_score", 16'd0);
        expect_val("restart_paddle", 16'd288);
        compare(16'(lives));
        compare(score);
        compare(16'(paddleX));
        hold(1'b0, 1'b0);
        serve();

        expect_val("priority_state", 16'd4);
        expect_val("priority_lives", 16'd3);
        ballLost = 1'b1;
        bricksCleared = 1'b1;
        tick();
        ballLost = 1'b0;
        bricksCleared = 1'b0;
        compare(16'(gameState));
        compare(16'(lives));

        leftButton = 1'b1;
        wait_state(3'd1, "win_restart");
        hold(1'b0, 1'b0);
        serve();
        repeat (3) begin
            brickHit = 1'b1;
            tick();
            brickHit = 1'b0;
            tick();
        end
        hold(1'b0, 1'b1);
        step_frame(1, 1'b1);
        reset = 1'b1;
        tick();
        check_reset();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
